// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes and responder state encoding
// Purpose: opcode constants and FSM state type used by the ALU responder,
//          the combinational ALU and any request generator.
// Ports:   none (package)
package alu_pkg;
   localparam logic [3:0] ALU_AND   = 4'h0;
   localparam logic [3:0] ALU_OR    = 4'h1;
   localparam logic [3:0] ALU_ADD   = 4'h2;
   localparam logic [3:0] ALU_SUB   = 4'h6;
   localparam logic [3:0] ALU_PASSB = 4'h7;
   localparam logic [3:0] ALU_MUL   = 4'hA;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier, one bit per cycle
// Purpose: computes the low WIDTH bits of i_a * i_b over WIDTH steps.
// Ports:   Clk, Reset       clock, async active-high reset
//          i_start          latch operands and begin (ignored mid-run only by caller)
//          i_a, i_b         operands, sampled on i_start
//          o_done           high during the final step; o_product is valid then
//          o_product        accumulator including the current step's partial product
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_done,
   output logic [WIDTH-1:0] o_product
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_acc;
   logic [CW-1:0]    r_cnt;
   logic             r_run;
   logic [WIDTH-1:0] w_partial;
   logic [WIDTH-1:0] w_acc_next;

   // Multiplicand shifts left and multiplier right, so bit 0 of the
   // multiplier always selects the correctly weighted partial product.
   assign w_partial  = r_mplier[0] ? r_mcand : '0;
   assign w_acc_next = r_acc + w_partial;
   assign o_done     = r_run && (r_cnt == LAST);
   assign o_product  = w_acc_next;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_run    <= 1'b0;
      end else if (i_start) begin
         r_mcand  <= i_a;
         r_mplier <= i_b;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_run    <= 1'b1;
      end else if (r_run) begin
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
         if (r_cnt == LAST) begin
            r_run <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/alu_responder.sv
// rtl/alu_responder.sv - handshaked registered ALU with iterative multiply
// Purpose: accepts one ALU op per InValid/InReady handshake and returns the
//          registered result on an OutValid/OutReady channel.
// Ports:   Clk, Reset            clock, async active-high reset
//          InValid/InReady       request handshake (InReady combinational)
//          BusA, BusB, ALUCtrl   operands and opcode, sampled at acceptance
//          OutValid/OutReady     result handshake
//          BusW, Zero, Err       registered result, zero flag, unsupported-op flag
//          Busy                  multiply in progress
module alu_responder
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] BusA,
   input  logic [WIDTH-1:0] BusB,
   input  logic [3:0]       ALUCtrl,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] BusW,
   output logic             Zero,
   output logic             Err,
   output logic             Busy
);
   state_t           r_state;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_bus_w;
   logic             r_zero;
   logic             r_err;
   logic             r_busy;

   logic             w_accept;
   logic             w_is_mul;
   logic             w_mul_done;
   logic [WIDTH-1:0] w_mul_product;
   logic [WIDTH-1:0] w_result;
   logic             w_err;

   // A result leaving this cycle frees the output slot for a new one.
   assign InReady  = (r_state == S_IDLE) && (!r_out_valid || OutReady);
   assign w_accept = InValid && InReady;
   assign w_is_mul = (ALUCtrl == ALU_MUL);

   assign OutValid = r_out_valid;
   assign BusW     = r_bus_w;
   assign Zero     = r_zero;
   assign Err      = r_err;
   assign Busy     = r_busy;

   always_comb begin
      w_result = '0;
      w_err    = 1'b0;
      case (ALUCtrl)
         ALU_AND:   w_result = BusA & BusB;
         ALU_OR:    w_result = BusA | BusB;
         ALU_ADD:   w_result = BusA + BusB;
         ALU_SUB:   w_result = BusA - BusB;
         ALU_PASSB: w_result = BusB;
         ALU_MUL:   w_result = '0;
         default:   w_err    = 1'b1;
      endcase
   end

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .Clk       (Clk),
      .Reset     (Reset),
      .i_start   (w_accept && w_is_mul),
      .i_a       (BusA),
      .i_b       (BusB),
      .o_done    (w_mul_done),
      .o_product (w_mul_product)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state     <= S_IDLE;
         r_out_valid <= 1'b0;
         r_bus_w     <= '0;
         r_zero      <= 1'b0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
      end else if (r_state == S_IDLE) begin
         if (r_out_valid && OutReady) begin
            r_out_valid <= 1'b0;
         end
         if (w_accept) begin
            if (w_is_mul) begin
               r_state <= S_MUL;
               r_busy  <= 1'b1;
            end else begin
               r_bus_w     <= w_result;
               r_zero      <= (w_result == '0);
               r_err       <= w_err;
               r_out_valid <= 1'b1;
            end
         end
      end else begin
         // The output slot was free on entry, so nothing is pending here.
         if (w_mul_done) begin
            r_bus_w     <= w_mul_product;
            r_zero      <= (w_mul_product == '0);
            r_err       <= 1'b0;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
         end
      end
   end
endmodule
